// File: rtl/ext_b_resp_tracker_if.sv
// rtl/ext_b_resp_tracker_if.sv - handshake bundle for the per-TID B response tracker
//
// Carries the three handshakes of ext_b_resp_tracker: burst issue (AW side),
// B-channel beats from the upstream B buffer, and transfer completion (done),
// plus the unexpected-B pulse. Signal suffixes are from the tracker's point
// of view (_i = into the tracker, _o = out of it).
//
// Parameters:
//   ID_WIDTH   - AXI B-channel ID width
//   USER_WIDTH - AXI B-channel user width; low TID_WIDTH bits carry the TID
//   NB_TID     - number of tracked transfers; TID_WIDTH = $clog2(NB_TID)
//
// Modports:
//   slave  - the tracker itself
//   master - the environment driving issue/B/done_ready
interface ext_b_resp_tracker_if #(
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 6,
   parameter int NB_TID     = 4
);
   localparam int TID_WIDTH = $clog2(NB_TID);

   logic                  issue_valid_i;
   logic                  issue_ready_o;
   logic [TID_WIDTH-1:0]  issue_tid_i;
   logic                  issue_last_i;

   logic                  b_valid_i;
   logic                  b_ready_o;
   logic [1:0]            b_resp_i;
   logic [ID_WIDTH-1:0]   b_id_i;
   logic [USER_WIDTH-1:0] b_user_i;

   logic                  done_valid_o;
   logic                  done_ready_i;
   logic [TID_WIDTH-1:0]  done_tid_o;
   logic                  done_err_o;

   logic                  unexp_o;

   modport slave (
      input  issue_valid_i, issue_tid_i, issue_last_i,
      input  b_valid_i, b_resp_i, b_id_i, b_user_i,
      input  done_ready_i,
      output issue_ready_o, b_ready_o,
      output done_valid_o, done_tid_o, done_err_o,
      output unexp_o
   );

   modport master (
      output issue_valid_i, issue_tid_i, issue_last_i,
      output b_valid_i, b_resp_i, b_id_i, b_user_i,
      output done_ready_i,
      input  issue_ready_o, b_ready_o,
      input  done_valid_o, done_tid_o, done_err_o,
      input  unexp_o
   );
endinterface

// File: rtl/ext_b_resp_tracker.sv
// rtl/ext_b_resp_tracker.sv - per-TID outstanding-burst tracker on the AXI B channel
//
// Counts AW bursts issued per transfer ID (TID) and retires them as B beats
// arrive (TID taken from b_user[TID_WIDTH-1:0]). Once the last burst of a
// transfer has been issued and every burst has its B response, the TID is
// marked pending and reported on the done handshake, lowest TID first.
//
// Ports:
//   clk_i  - clock, all state on its rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - ext_b_resp_tracker_if.slave:
//              issue_valid_i/issue_ready_o, issue_tid_i, issue_last_i
//              b_valid_i/b_ready_o, b_resp_i, b_id_i (ignored), b_user_i
//              done_valid_o/done_ready_i, done_tid_o, done_err_o
//              unexp_o (one-cycle pulse: B for a TID with nothing outstanding)
//
// Configuration macro:
//   EXT_B_RESP_ERR_EN - when defined, SLVERR/DECERR (b_resp_i[1]) on a counted
//                       beat sets a sticky per-TID error reported on done_err_o.
//                       When undefined, no error state exists and done_err_o=0.
module ext_b_resp_tracker #(
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 6,
   parameter int NB_TID     = 4,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ext_b_resp_tracker_if.slave  bus
);
   localparam int TID_WIDTH = $clog2(NB_TID);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic [CNT_WIDTH-1:0] cnt_q [NB_TID];
   logic [CNT_WIDTH-1:0] cnt_d [NB_TID];
   logic [NB_TID-1:0]    last_q, last_d;
   logic [NB_TID-1:0]    pend_q, pend_d;

   logic                 done_valid_q, done_valid_d;
   logic [TID_WIDTH-1:0] done_tid_q, done_tid_d;
   logic                 unexp_q, unexp_d;

`ifdef EXT_B_RESP_ERR_EN
   logic [NB_TID-1:0]    err_q, err_d;
   logic                 done_err_q, done_err_d;
`endif

   logic [TID_WIDTH-1:0] b_tid;
   logic                 issue_hs;
   logic                 b_counted;
   logic                 done_hs;
   logic                 sel_valid;
   logic [TID_WIDTH-1:0] sel_tid;

   // b_id_i is accepted but never used; upper user bits and b_resp_i[0]
   // carry nothing for the tracker.
   logic                 unused_bits;
   assign unused_bits = ^{bus.b_id_i, bus.b_resp_i, bus.b_user_i};

   assign b_tid = bus.b_user_i[TID_WIDTH-1:0];

   // Every beat is consumed in its handshake cycle, so no back-pressure.
   assign bus.b_ready_o = 1'b1;

   // A TID that is full, already has its last burst, or is waiting to be
   // reported must not accept new bursts; this also keeps cnt from wrapping up.
   assign bus.issue_ready_o = !((cnt_q[bus.issue_tid_i] == CNT_MAX) ||
                                pend_q[bus.issue_tid_i] ||
                                last_q[bus.issue_tid_i]);

   assign issue_hs  = bus.issue_valid_i & bus.issue_ready_o;
   // Only a beat for a TID with bursts outstanding is counted; this keeps cnt
   // from wrapping down and identifies unexpected beats.
   assign b_counted = bus.b_valid_i & (cnt_q[b_tid] != '0);
   assign done_hs   = done_valid_q & bus.done_ready_i;

   always_comb begin
      unexp_d = bus.b_valid_i & ~b_counted;
      last_d  = last_q;
      pend_d  = pend_q;
`ifdef EXT_B_RESP_ERR_EN
      err_d   = err_q;
`endif
      for (int t = 0; t < NB_TID; t++) begin
         cnt_d[t] = cnt_q[t];

         // Issue and counted B to the same TID cancel each other.
         if ((issue_hs && bus.issue_tid_i == TID_WIDTH'(t)) &&
             !(b_counted && b_tid == TID_WIDTH'(t)))
            cnt_d[t] = cnt_q[t] + 1'b1;
         else if (!(issue_hs && bus.issue_tid_i == TID_WIDTH'(t)) &&
                  (b_counted && b_tid == TID_WIDTH'(t)))
            cnt_d[t] = cnt_q[t] - 1'b1;

         if (issue_hs && bus.issue_last_i && bus.issue_tid_i == TID_WIDTH'(t))
            last_d[t] = 1'b1;

         if (done_hs && done_tid_q == TID_WIDTH'(t)) begin
            pend_d[t] = 1'b0;
`ifdef EXT_B_RESP_ERR_EN
            err_d[t]  = 1'b0;
`endif
         end

`ifdef EXT_B_RESP_ERR_EN
         if (b_counted && bus.b_resp_i[1] && b_tid == TID_WIDTH'(t))
            err_d[t] = 1'b1;
`endif

         // Transfer complete: all bursts answered and the last one issued.
         if (cnt_d[t] == '0 && last_d[t]) begin
            pend_d[t] = 1'b1;
            last_d[t] = 1'b0;
         end
      end
   end

   // Lowest-index pending TID, looked at on next-state so a completion or
   // handshake at this edge is visible on done_* right after it.
   always_comb begin
      sel_valid = |pend_d;
      sel_tid   = '0;
      for (int t = NB_TID - 1; t >= 0; t--) begin
         if (pend_d[t])
            sel_tid = TID_WIDTH'(t);
      end
   end

   // The presented TID is latched: a lower TID completing while the consumer
   // stalls must not change done_tid_o under an open handshake.
   always_comb begin
      done_valid_d = done_valid_q;
      done_tid_d   = done_tid_q;
`ifdef EXT_B_RESP_ERR_EN
      done_err_d   = done_err_q;
`endif
      if (!done_valid_q || done_hs) begin
         done_valid_d = sel_valid;
         done_tid_d   = sel_tid;
`ifdef EXT_B_RESP_ERR_EN
         done_err_d   = sel_valid & err_d[sel_tid];
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int t = 0; t < NB_TID; t++)
            cnt_q[t] <= '0;
         last_q       <= '0;
         pend_q       <= '0;
         done_valid_q <= 1'b0;
         done_tid_q   <= '0;
         unexp_q      <= 1'b0;
`ifdef EXT_B_RESP_ERR_EN
         err_q        <= '0;
         done_err_q   <= 1'b0;
`endif
      end else begin
         for (int t = 0; t < NB_TID; t++)
            cnt_q[t] <= cnt_d[t];
         last_q       <= last_d;
         pend_q       <= pend_d;
         done_valid_q <= done_valid_d;
         done_tid_q   <= done_tid_d;
         unexp_q      <= unexp_d;
`ifdef EXT_B_RESP_ERR_EN
         err_q        <= err_d;
         done_err_q   <= done_err_d;
`endif
      end
   end

   assign bus.done_valid_o = done_valid_q;
   assign bus.done_tid_o   = done_tid_q;
   assign bus.unexp_o      = unexp_q;
`ifdef EXT_B_RESP_ERR_EN
   assign bus.done_err_o   = done_err_q;
`else
   assign bus.done_err_o   = 1'b0;
`endif

endmodule

// File: doc/ext_b_resp_tracker.md
EXT_B_RESP_TRACKER -- requirements
Module: ext_b_resp_tracker

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, the AXI B-channel ID width.
REQ-002 The block SHALL have parameter USER_WIDTH, default 6, the AXI B-channel user width; bits [TID_WIDTH-1:0] carry the transfer ID (TID).
REQ-003 The block SHALL have parameter NB_TID, default 4, the number of tracked transfers; TID_WIDTH = $clog2(NB_TID).
REQ-004 The block SHALL have parameter CNT_WIDTH, default 4, the width of each per-TID outstanding-burst counter.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-006 clk_i  in  1  clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  asynchronous active-high reset.
REQ-008 issue_valid_i / issue_ready_o  in/out  1/1  handshake for one AW burst issued.
REQ-009 issue_tid_i  in  TID_WIDTH  TID of the issued burst.
REQ-010 issue_last_i  in  1  issued burst is the last burst of its transfer.
REQ-011 b_valid_i / b_ready_o  in/out  1/1  B-channel handshake from the upstream B buffer.
REQ-012 b_resp_i  in  2  AXI response code.
REQ-013 b_id_i  in  ID_WIDTH  AXI ID; accepted and ignored.
REQ-014 b_user_i  in  USER_WIDTH  user field; TID = b_user_i[TID_WIDTH-1:0].
REQ-015 done_valid_o / done_ready_i  out/in  1/1  transfer-completion handshake.
REQ-016 done_tid_o  out  TID_WIDTH  TID of the completed transfer.
REQ-017 done_err_o  out  1  at least one burst of the transfer returned SLVERR or DECERR.
REQ-018 unexp_o  out  1  one-cycle pulse: B received for a TID with zero outstanding bursts.

Function
REQ-019 Per TID the block SHALL hold cnt (CNT_WIDTH), last flag, err flag and pend flag.
REQ-020 b_ready_o SHALL be constant 1 out of reset; every B beat is consumed in its handshake cycle.
REQ-021 An issue handshake SHALL increment cnt[issue_tid_i] and, if issue_last_i=1, set last[issue_tid_i].
REQ-022 A B handshake with cnt[tid]>0 SHALL decrement cnt[tid]; with cnt[tid]=0 it SHALL leave state unchanged and pulse unexp_o in the next cycle.
REQ-023 Issue and B to the same TID in the same cycle SHALL leave cnt unchanged; to different TIDs, both SHALL apply.
REQ-024 When cnt[t]=0 and last[t]=1 after the update, pend[t] SHALL be set and last[t] cleared in the same edge.
REQ-025 done_valid_o SHALL be high when any pend is set; done_tid_o SHALL be the lowest-index pending TID; both driven from registers only, so B handshake at edge N gives done_valid_o at cycle N+1.
REQ-026 done_tid_o and done_err_o SHALL be held stable while done_valid_o=1 and done_ready_i=0.
REQ-027 A done handshake SHALL clear pend and err of the presented TID.
REQ-028 issue_ready_o SHALL be 0 when cnt[issue_tid_i] is all-ones, or when pend[issue_tid_i] or last[issue_tid_i] is set; otherwise 1. It is combinational on issue_tid_i and registered state.
REQ-029 Counters SHALL never wrap in either direction.

Reset
REQ-030 While rst_i=1, all cnt, last, pend and err SHALL be 0, and issue_ready_o=1, b_ready_o=1, done_valid_o=0, done_tid_o=0, done_err_o=0, unexp_o=0.
REQ-031 Reset asserted mid-transfer SHALL discard all tracking state immediately, with no done emitted for that transfer.

Configuration
REQ-032 With EXT_B_RESP_ERR_EN defined, b_resp_i[1]=1 on a counted B beat SHALL set err[tid], and done_err_o SHALL reflect err of the presented TID.
REQ-033 Without EXT_B_RESP_ERR_EN, no err storage SHALL exist, b_resp_i SHALL be ignored, and done_err_o SHALL be constant 0.

Verification
REQ-034 Issue 3 bursts on TID 2, the last with issue_last_i=1, then 3 OKAY B beats with user=2 -> done_valid_o=1 with done_tid_o=2 and done_err_o=0 one cycle after the third B.
REQ-035 Issue 1 last burst on TID 1, then B with resp=2'b10, with EXT_B_RESP_ERR_EN defined -> done_tid_o=1, done_err_o=1; without the macro -> done_err_o=0.
REQ-036 B with user=3 while cnt[3]=0 -> unexp_o pulses for exactly 1 cycle, and no cnt changes.
REQ-037 Issue 15 bursts to TID 0 with CNT_WIDTH=4 and no B -> issue_ready_o=0 for TID 0 and 1 for TID 1; one B to TID 0 -> issue_ready_o returns to 1.
REQ-038 TIDs 0 and 3 complete in the same cycle with done_ready_i=0 for 2 cycles -> done_tid_o held at 0; after the handshake, done_tid_o=3 on the next cycle.
REQ-039 Assert rst_i with cnt[1]=2 and last[1]=1 -> all outputs take their reset values; no done is produced after reset is released.
